pkt_stim_gen: RTL and testbench

- Parametrised packet stimulus source for bench and bring-up use.
- Plays a programmable table of (data, ctl) words onto the packet bus, using the existing control encoding:
  - 0x00 invalid
  - 0x01 start
  - 0x02 stop
  - 0x03 single-cycle packet
- Adds ready/valid backpressure, a configurable inter-word gap, play length, repeat mode and packet counting.
- Sits upstream of the parser/pipeline input in place of hand-written stimulus.

---
 rtl/pkt_stim_gen.sv | 176 +++++++++++++++++
 tb/tb_pkt_stim_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_stim_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pkt_stim_gen : plays a table of (data, ctl) words onto a ready/valid bus
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
module pkt_stim_gen #(
    parameter int DATA_W = 512,
    parameter int CTL_W  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int GAP    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CTL_W-1:0]  load_ctl,
    input  logic [ADDR_W:0]   num_words,
    input  logic              repeat_en,
    input  logic              start,
    input  logic              abort,
    output logic [DATA_W-1:0] out_data,
    output logic [CTL_W-1:0]  out_ctl,
    output logic              out_valid,
    input  logic              out_rdy,
    output logic              busy,
    output logic              done,
    output logic [15:0]       pkt_cnt
);
    localparam int                GCNT_W       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CTL_W-1:0]  c_ctl_stop   = CTL_W'(2);
    localparam logic [CTL_W-1:0]  c_ctl_single = CTL_W'(3);
    localparam logic [ADDR_W:0]   c_depth      = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [DATA_W-1:0]  r_mem_data [DEPTH];
    logic [CTL_W-1:0]   r_mem_ctl  [DEPTH];
    logic [ADDR_W-1:0]  r_ptr, w_ptr_nxt;
    logic [ADDR_W-1:0]  r_last, w_last_nxt;
    logic               r_rep, w_rep_nxt;
    logic [GCNT_W-1:0]  r_gcnt, w_gcnt_nxt;
    logic [DATA_W-1:0]  w_data_nxt;
    logic [CTL_W-1:0]   w_ctl_nxt;
    logic               w_valid_nxt, w_busy_nxt, w_done_nxt;
    logic [15:0]        w_cnt_nxt;
    logic               w_accept, w_is_last;
    logic [ADDR_W-1:0]  w_adv_ptr;
    logic [ADDR_W:0]    w_len;

    // Table is deliberately left out of reset so a replay after reset reuses it.
    always_ff @(posedge clk) begin
        if (load_en && !busy) begin
            r_mem_data[load_addr] <= load_data;
            r_mem_ctl[load_addr]  <= load_ctl;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_last_nxt  = r_last;
        w_rep_nxt   = r_rep;
        w_gcnt_nxt  = r_gcnt;
        w_data_nxt  = out_data;
        w_ctl_nxt   = out_ctl;
        w_valid_nxt = out_valid;
        w_busy_nxt  = busy;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = pkt_cnt;
        w_accept    = out_valid && out_rdy;
        w_is_last   = (r_ptr == r_last);
        w_adv_ptr   = w_is_last ? '0 : r_ptr + 1'b1;
        w_len       = (num_words > c_depth) ? c_depth : num_words;

        if (abort) begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
            w_ctl_nxt   = '0;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && (num_words != '0)) begin
                        w_state_nxt = S_SEND;
                        w_ptr_nxt   = '0;
                        // A length of DEPTH truncates to 0, so the subtraction wraps to DEPTH-1.
                        w_last_nxt  = w_len[ADDR_W-1:0] - 1'b1;
                        w_rep_nxt   = repeat_en;
                        w_data_nxt  = r_mem_data[0];
                        w_ctl_nxt   = r_mem_ctl[0];
                        w_valid_nxt = 1'b1;
                        w_busy_nxt  = 1'b1;
                    end
                end
                S_SEND: begin
                    if (w_accept) begin
                        if ((out_ctl == c_ctl_stop) || (out_ctl == c_ctl_single)) begin
                            w_cnt_nxt = pkt_cnt + 16'd1;
                        end
                        if (w_is_last && !r_rep) begin
                            w_state_nxt = S_IDLE;
                            w_valid_nxt = 1'b0;
                            w_ctl_nxt   = '0;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_ptr_nxt = w_adv_ptr;
                            if (GAP > 0) begin
                                w_state_nxt = S_GAP;
                                w_valid_nxt = 1'b0;
                                w_ctl_nxt   = '0;
                                w_gcnt_nxt  = GCNT_W'(GAP - 1);
                            end else begin
                                w_data_nxt = r_mem_data[w_adv_ptr];
                                w_ctl_nxt  = r_mem_ctl[w_adv_ptr];
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (r_gcnt == '0) begin
                        w_state_nxt = S_SEND;
                        w_data_nxt  = r_mem_data[r_ptr];
                        w_ctl_nxt   = r_mem_ctl[r_ptr];
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_gcnt_nxt = r_gcnt - 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                    w_ctl_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_last    <= '0;
            r_rep     <= 1'b0;
            r_gcnt    <= '0;
            out_data  <= '0;
            out_ctl   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pkt_cnt   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_last    <= w_last_nxt;
            r_rep     <= w_rep_nxt;
            r_gcnt    <= w_gcnt_nxt;
            out_data  <= w_data_nxt;
            out_ctl   <= w_ctl_nxt;
            out_valid <= w_valid_nxt;
            busy      <= w_busy_nxt;
            done      <= w_done_nxt;
            pkt_cnt   <= w_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pkt_stim_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pkt_stim_gen : directed bench for pkt_stim_gen (GAP=1 and GAP=0 instances)
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
module tb_pkt_stim_gen;
    localparam int DW = 32;
    localparam int CW = 8;
    localparam int DEPTH = 4;
    localparam int AW = 2;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } word_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;
    logic [CW-1:0] load_ctl = '0;
    logic [AW:0]   num_words = '0;
    logic          repeat_en = 1'b0;
    logic          start0 = 1'b0, start1 = 1'b0;
    logic          abort = 1'b0;
    logic          out_rdy = 1'b1;

    logic [DW-1:0] out_data0, out_data1;
    logic [CW-1:0] out_ctl0, out_ctl1;
    logic          out_valid0, out_valid1, busy0, busy1, done0, done1;
    logic [15:0]   pkt_cnt0, pkt_cnt1;

    int            total = 0;
    int            passed = 0;
    word_t         q0[$], q1[$];
    word_t         tbl[DEPTH];
    word_t         e0, e1;
    logic [15:0]   exp_cnt0 = '0, exp_cnt1 = '0;
    bit            auto1 = 1'b0;

    always #5 clk = ~clk;

    pkt_stim_gen #(.DATA_W(DW), .CTL_W(CW), .DEPTH(DEPTH), .ADDR_W(AW), .GAP(1)) u_gap1 (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .load_ctl(load_ctl), .num_words(num_words),
        .repeat_en(repeat_en), .start(start0), .abort(abort),
        .out_data(out_data0), .out_ctl(out_ctl0), .out_valid(out_valid0),
        .out_rdy(out_rdy), .busy(busy0), .done(done0), .pkt_cnt(pkt_cnt0)
    );

    pkt_stim_gen #(.DATA_W(DW), .CTL_W(CW), .DEPTH(DEPTH), .ADDR_W(AW), .GAP(0)) u_gap0 (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .load_ctl(load_ctl), .num_words(num_words),
        .repeat_en(repeat_en), .start(start1), .abort(abort),
        .out_data(out_data1), .out_ctl(out_ctl1), .out_valid(out_valid1),
        .out_rdy(out_rdy), .busy(busy1), .done(done1), .pkt_cnt(pkt_cnt1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Scoreboards: a word is popped when it will be accepted at the coming edge.
    always @(negedge clk) begin
        #1;
        if (!reset) begin
            q0.delete();
            exp_cnt0 = '0;
        end else if (!abort && out_valid0 && out_rdy) begin
            if (q0.size() == 0) begin
                chk("g1_extra_word", 64'(q0.size()), 64'd1);
            end else begin
                e0 = q0.pop_front();
                chk("g1_word", 64'({out_data0, out_ctl0}), 64'(e0));
                if (e0.c == 8'h02 || e0.c == 8'h03) exp_cnt0++;
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (!reset) begin
            q1.delete();
            exp_cnt1 = '0;
        end else if (!abort && out_valid1 && out_rdy) begin
            if (auto1) begin
                exp_cnt1++;
            end else if (q1.size() == 0) begin
                chk("g0_extra_word", 64'(q1.size()), 64'd1);
            end else begin
                e1 = q1.pop_front();
                chk("g0_word", 64'({out_data1, out_ctl1}), 64'(e1));
                if (e1.c == 8'h02 || e1.c == 8'h03) exp_cnt1++;
            end
        end
    end

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [CW-1:0] c);
        load_en = 1'b1; load_addr = a; load_data = d; load_ctl = c;
        tbl[a] = '{d: d, c: c};
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic push_play(input int which, input int n);
        int eff;
        eff = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < eff; i++) begin
            if (which == 0) q0.push_back(tbl[i]);
            else            q1.push_back(tbl[i]);
        end
    endtask

    task automatic start_play(input int which, input int n, input bit rep);
        num_words = 3'(n);
        repeat_en = rep;
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int which, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if ((which == 0) ? done0 : done1) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    initial begin
        logic [7:0] ectl [0:9];
        bit any_done;
        ectl[0] = 8'h00; ectl[1] = 8'h01; ectl[2] = 8'h00; ectl[3] = 8'h02; ectl[4] = 8'h00;
        ectl[5] = 8'h03; ectl[6] = 8'h00; ectl[7] = 8'h00; ectl[8] = 8'h00; ectl[9] = 8'h00;

        repeat (2) @(negedge clk);
        chk("rst_g1", 64'({out_data0, out_ctl0, out_valid0, busy0, done0, pkt_cnt0}), 64'd0);
        chk("rst_g0", 64'({out_data1, out_ctl1, out_valid1, busy1, done1, pkt_cnt1}), 64'd0);
        reset = 1'b1;

        load(0, 32'hA, 8'h01);
        load(1, 32'hB, 8'h02);
        load(2, 32'hC, 8'h03);
        load(3, 32'hD, 8'h00);

        // GAP=1 timing: words at cycles 1,3,5,7, done at 8
        push_play(0, 4);
        start_play(0, 4, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) @(negedge clk);
            chk($sformatf("t1_cyc%0d", k), 64'({out_valid0, done0, busy0, out_ctl0}),
                64'({((k % 2) == 1 && k <= 7), (k == 8), (k < 8), ectl[k]}));
        end
        chk("t1_queue_empty", 64'(q0.size()), 64'd0);
        chk("t1_pkt_cnt", 64'(pkt_cnt0), 64'd2);

        // GAP=0 with out_rdy low cycles 2-4
        push_play(1, 4);
        start_play(1, 4, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) @(negedge clk);
            out_rdy = !(k >= 2 && k <= 4);
            if (k >= 2 && k <= 4)
                chk($sformatf("t2_hold%0d", k), 64'({out_data1, out_ctl1, out_valid1}),
                    64'({32'hB, 8'h02, 1'b1}));
            if (k == 8) chk("t2_done", 64'(done1), 64'd1);
        end
        out_rdy = 1'b1;
        chk("t2_queue_empty", 64'(q1.size()), 64'd0);
        chk("t2_pkt_cnt", 64'(pkt_cnt1), 64'(exp_cnt1));

        // repeat mode, two entries, abort at cycle 10
        for (int i = 0; i < 9; i++) q1.push_back(tbl[i % 2]);
        start_play(1, 2, 1'b1);
        any_done = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 10) abort = 1'b1;
            any_done = any_done | done1;
        end
        @(negedge clk);
        abort = 1'b0;
        chk("t3_abort_idle", 64'({out_valid1, busy1, out_ctl1}), 64'd0);
        chk("t3_no_done", 64'(any_done | done1), 64'd0);
        chk("t3_queue_empty", 64'(q1.size()), 64'd0);
        chk("t3_pkt_cnt", 64'(pkt_cnt1), 64'(exp_cnt1));
        repeat_en = 1'b0;

        // num_words=0 ignored; num_words=7 plays exactly DEPTH words
        start_play(0, 0, 1'b0);
        chk("t4_zero_idle", 64'({out_valid0, busy0, done0}), 64'd0);
        @(negedge clk);
        chk("t4_zero_idle2", 64'({out_valid0, busy0}), 64'd0);
        push_play(0, 7);
        start_play(0, 7, 1'b0);
        wait_done(0, "t4_len7_done");
        chk("t4_len7_queue", 64'(q0.size()), 64'd0);

        // load while busy is ignored
        push_play(0, 4);
        start_play(0, 4, 1'b0);
        load_en = 1'b1; load_addr = 2'd1; load_data = 32'hEE; load_ctl = 8'h03;
        @(negedge clk);
        load_en = 1'b0;
        wait_done(0, "t5_busy_done");
        push_play(0, 4);
        start_play(0, 4, 1'b0);
        wait_done(0, "t5_replay_done");
        chk("t5_replay_queue", 64'(q0.size()), 64'd0);

        // reset mid-SEND, then replay from the retained table
        push_play(0, 4);
        start_play(0, 4, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_rst_g1", 64'({out_data0, out_ctl0, out_valid0, busy0, done0, pkt_cnt0}), 64'd0);
        chk("t6_rst_g0", 64'({out_data1, out_ctl1, out_valid1, busy1, done1, pkt_cnt1}), 64'd0);
        reset = 1'b1;
        push_play(0, 4);
        start_play(0, 4, 1'b0);
        wait_done(0, "t6_replay_done");
        chk("t6_replay_queue", 64'(q0.size()), 64'd0);
        chk("t6_pkt_cnt", 64'(pkt_cnt0), 64'd2);

        // pkt_cnt wrap: 65535 single-cycle packets then one stop
        for (int i = 0; i < DEPTH; i++) load(AW'(i), 32'h33, 8'h03);
        auto1 = 1'b1;
        start_play(1, 4, 1'b1);
        for (int g = 0; g < 70000 && exp_cnt1 != 16'hFFFF; g++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        auto1 = 1'b0;
        repeat_en = 1'b0;
        chk("t7_reach_ffff", 64'(exp_cnt1), 64'hFFFF);
        chk("t7_cnt_ffff", 64'(pkt_cnt1), 64'hFFFF);
        load(0, 32'h55, 8'h02);
        push_play(1, 1);
        start_play(1, 1, 1'b0);
        wait_done(1, "t7_done");
        chk("t7_cnt_wrap", 64'(pkt_cnt1), 64'd0);
        chk("t7_queue_empty", 64'(q1.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
